// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - parity mode constants
//   - expected_parity(): parity bit a transmitter would append to a byte
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    // Unused upper data bits must be zero so they do not disturb the XOR.
    function automatic logic expected_parity(input logic [7:0] d, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample and bit-period tick generator (shared by the RX and TX sides).
// Ports:
//   clk, rstn     clock, async active-low reset
//   en_i          low = synchronous clear of both counters
//   baud_div_i    clk cycles per oversample tick, 0 treated as 1, sampled live
//   ostick_o      one-cycle pulse per oversample tick
//   bit_tick_o    one-cycle pulse every OVERSAMPLE osticks, free-running
module uart_baud_tick #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en_i,
    input  logic [15:0] baud_div_i,
    output logic        ostick_o,
    output logic        bit_tick_o
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);

    logic [15:0]     div_cnt_q, div_cnt_d;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic            ostick_q, ostick_d;
    logic            bit_tick_q, bit_tick_d;
    logic [15:0]     term_c;
    logic            wrap_c;

    // Comparing with >= lets a shrinking baud_div wrap a counter already past the new terminal.
    always_comb begin
        term_c     = (baud_div_i == 16'd0) ? 16'd0 : baud_div_i - 16'd1;
        wrap_c     = (div_cnt_q >= term_c);
        div_cnt_d  = wrap_c ? 16'd0 : div_cnt_q + 16'd1;
        ostick_d   = wrap_c;
        os_cnt_d   = os_cnt_q;
        bit_tick_d = 1'b0;
        if (ostick_q) begin
            if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                os_cnt_d   = '0;
                bit_tick_d = 1'b1;
            end else begin
                os_cnt_d = os_cnt_q + OS_W'(1);
            end
        end
        if (!en_i) begin
            div_cnt_d  = '0;
            os_cnt_d   = '0;
            ostick_d   = 1'b0;
            bit_tick_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q  <= '0;
            os_cnt_q   <= '0;
            ostick_q   <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            os_cnt_q   <= os_cnt_d;
            ostick_q   <= ostick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign ostick_o   = ostick_q;
    assign bit_tick_o = bit_tick_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer with oversampling and 3-sample majority vote.
// Ports:
//   clk, rstn     clock, async active-low reset
//   en            low = synchronous clear to idle
//   baud_div      clk cycles per oversample tick (0 treated as 1)
//   rxd           asynchronous serial input, idle high
//   data          last received byte, LSB-aligned, held until next valid
//   valid         one-cycle strobe qualifying data/parity_err/frame_err
//   parity_err    parity mismatch for the current valid
//   frame_err     first stop bit sampled low for the current valid
//   bit_tick      free-running bit-period pulse
//   busy          FSM not idle
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [15:0] baud_div,
    input  logic        rxd,
    output logic [7:0]  data,
    output logic        valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        bit_tick,
    output logic        busy
);

    localparam int unsigned PH_W     = $clog2(OVERSAMPLE);
    localparam int unsigned HALF     = OVERSAMPLE / 2;
    localparam logic [PH_W-1:0] PH_RESOLVE = PH_W'(HALF + 1);
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OVERSAMPLE - 1);

    // Only the first stop bit is examined; a second one needs no receiver logic.
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    end

    logic            ostick;
    logic            rx_meta_q, rx_meta_d;
    logic            rxs_q, rxs_d;
    logic            rxs_prev_q, rxs_prev_d;
    logic [2:0]      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [1:0]      smp_q, smp_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_err_q, par_err_d;
    logic [PH_W-1:0] brk_cnt_q, brk_cnt_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;

    logic            fall_c, vote_c, resolve_c, in_frame_c;
    logic [7:0]      shift_in_c;

    uart_baud_tick #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk        (clk),
        .rstn       (rstn),
        .en_i       (en),
        .baud_div_i (baud_div),
        .ostick_o   (ostick),
        .bit_tick_o (bit_tick)
    );

    // Next-state: synchroniser, sampling, FSM and output latches.
    always_comb begin
        rx_meta_d    = rxd;
        rxs_d        = rx_meta_q;
        rxs_prev_d   = rxs_q;
        state_d      = state_q;
        phase_d      = phase_q;
        smp_d        = smp_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        brk_cnt_d    = brk_cnt_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        fall_c     = rxs_prev_q & ~rxs_q;
        // Samples at phases H-1 and H are in smp_q; phase H+1 is the live rxs.
        vote_c     = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxs_q) | (smp_q[0] & rxs_q);
        resolve_c  = ostick && (phase_q == PH_RESOLVE);
        in_frame_c = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);

        shift_in_c                = shift_q >> 1;
        shift_in_c[DATA_BITS - 1] = vote_c;

        // Phase runs continuously across the frame; each wrap starts the next bit.
        if (in_frame_c && ostick) begin
            smp_d   = {smp_q[0], rxs_q};
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_c) begin
                    state_d   = ST_START;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    par_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (resolve_c) begin
                    state_d = vote_c ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (resolve_c) begin
                    shift_d   = shift_in_c;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (resolve_c) begin
                    par_err_d = vote_c ^ expected_parity(shift_q, PARITY);
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (resolve_c) begin
                    valid_d      = 1'b1;
                    data_d       = shift_q;
                    parity_err_d = (PARITY != PARITY_NONE) ? par_err_q : 1'b0;
                    frame_err_d  = ~vote_c;
                    if (!vote_c) begin
                        state_d   = ST_BREAK;
                        brk_cnt_d = '0;
                    end else if (fall_c) begin
                        // Next start edge coincides with this stop sample.
                        state_d   = ST_START;
                        phase_d   = '0;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        par_err_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                // Line must stay high for a full bit time before re-arming.
                if (ostick) begin
                    if (!rxs_q) begin
                        brk_cnt_d = '0;
                    end else if (brk_cnt_q == PH_LAST) begin
                        brk_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        brk_cnt_d = brk_cnt_q + PH_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!en) begin
            rx_meta_d    = 1'b1;
            rxs_d        = 1'b1;
            rxs_prev_d   = 1'b1;
            state_d      = ST_IDLE;
            phase_d      = '0;
            smp_d        = '1;
            bit_cnt_d    = '0;
            shift_d      = '0;
            par_err_d    = 1'b0;
            brk_cnt_d    = '0;
            data_d       = '0;
            valid_d      = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            smp_q        <= '1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            brk_cnt_q    <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            rxs_prev_q   <= rxs_prev_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            smp_q        <= smp_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            brk_cnt_q    <= brk_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive framer with oversampling. Recovers bytes from the asynchronous rxd line.
- Emits one-cycle byte strobes, which feed the watchdog monitor_in input.
- Emits a free-running bit-period tick, which feeds the watchdog cnt_pulse input, so link-idle timeout is counted in bit times.
- Sits directly upstream of the UART watchdog in the comm_uart receive path.

Parameters:
- OVERSAMPLE, 16, oversample ticks per bit; even, 8..32.
- DATA_BITS, 8, data bits per frame, 5..8, sent LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2; only the first stop bit is checked.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- en  in  1  high-active enable; low = synchronous clear to idle.
- baud_div  in  16  clk cycles per oversample tick; 0 is treated as 1.
- rxd  in  1  asynchronous serial input, idle high.
- data  out  8  received byte, LSB-aligned, upper bits 0 when DATA_BITS<8.
- valid  out  1  one-cycle pulse, data/parity_err/frame_err qualified.
- parity_err  out  1  parity mismatch for the current valid.
- frame_err  out  1  first stop bit sampled low for the current valid.
- bit_tick  out  1  one-cycle pulse every OVERSAMPLE oversample ticks, free-running.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (rstn low, asynchronous): sync flops = 1; all counters = 0; FSM = IDLE; data = 0; valid, parity_err, frame_err, bit_tick, busy = 0.
- en low: same values applied synchronously. baud_div is sampled live.
- Synchroniser: rxd passes through 2 flops (rxs). Input-to-FSM latency is 2 clk.
- Oversample tick (ostick): divider counts 0..baud_div-1 and pulses on the terminal count.
  - baud_div of 0 or 1 gives ostick every cycle.
  - A baud_div change takes effect at the next wrap; if the counter is already >= the new terminal, it wraps to 0.
- bit_tick: modulo-OVERSAMPLE counter of osticks, independent of FSM state. Pulses on the ostick that wraps it.
- Sampling: a 3-sample shift on ostick; the bit value is the majority vote of the samples at phases H-1, H, H+1, where H = OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rxs falling edge (1->0), clear the phase counter and go to START.
- START: at phase H+1, majority 0 -> phase counter restarts the bit, go to DATA. Majority 1 -> glitch, return to IDLE with no outputs.
- DATA: DATA_BITS bits sampled at mid-bit and shifted in LSB first.
  - After the last bit: go to PARITY if PARITY != 0, else STOP.
- PARITY: sample one bit. parity_err_int = received bit XOR expected bit.
  - Odd: expected = ~^data. Even: expected = ^data.
- STOP: sample the first stop bit at mid-bit. In the same cycle the sample resolves:
  - valid = 1 for one clk, with data, parity_err (0 when PARITY == 0) and frame_err = ~stop_sample.
  - Stop high: go to IDLE immediately, so a back-to-back start edge is caught; a second stop bit is not waited for.
  - Stop low: go to BREAK.
- BREAK: wait until rxs has been high for one full bit time (OVERSAMPLE osticks), then go to IDLE. No valid is issued during BREAK.
- Output latching: parity_err and frame_err are only meaningful while valid = 1 and are held until the next valid. data is held until the next valid.
- busy = (FSM != IDLE).
- Simultaneous events:
  - en falling mid-frame aborts the frame; no valid is issued.
  - A start edge arriving in the same cycle valid is issued is not missed; the STOP->IDLE transition and edge detect use the registered previous rxs.
- Bit-rate tolerance: frames whose bit periods deviate by up to ±3% from nominal must decode.

Decomposition:
- Package uart_pkg: FSM state enum (3-bit encoding), PARITY_NONE/ODD/EVEN constants, a function computing the expected parity bit.
- Sub-module uart_baud_tick: baud_div divider plus OVERSAMPLE counter, producing ostick and bit_tick. It is reusable by the TX side.
- The top level holds the synchroniser, FSM, shift register and majority vote.

Test Plan:
- Single byte: baud_div=4, OVERSAMPLE=16 (64 clk per bit), 8N1, send 0xA5 -> exactly one valid with data=0xA5, parity_err=0, frame_err=0; valid lands 9.5 bit times ±2 clk after the start edge; busy falls the same cycle.
- Parity: PARITY=2 (even), send 0x3C with parity bit 1 -> valid, data=0x3C, parity_err=1. Resend with parity bit 0 -> parity_err=0.
- Glitch and break:
  - 20-clk low pulse on idle rxd -> no valid; busy returns to 0 within one bit time.
  - rxd held low for 20 bit times -> one valid with data=0x00, frame_err=1; no further valid until rxd is high for 64 clk.
- Back-to-back and drift: three frames 0x01, 0x80, 0xFF sent with zero idle gap at a bit period of 62 clk (-3%) -> three valids in order, no errors.
- bit_tick: baud_div=4, idle line -> bit_tick pulses every 64 clk. Change baud_div to 2 -> period becomes 32 clk after at most one old period.
- Reset and enable:
  - rstn asserted mid-DATA -> all outputs 0 immediately without waiting for a clk edge; after release with rxd high, no spurious valid.
  - en low during the DATA state -> no valid; next frame decodes correctly.
